// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph table, FSM states and nibble lookup for seg7_multi_display
package seg7_pkg;

  // Active-high glyph bits, ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0     = 7'b0111111;
  localparam logic [6:0] GLYPH_1     = 7'b0000110;
  localparam logic [6:0] GLYPH_2     = 7'b1011011;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_4     = 7'b1100110;
  localparam logic [6:0] GLYPH_5     = 7'b1101101;
  localparam logic [6:0] GLYPH_6     = 7'b1111101;
  localparam logic [6:0] GLYPH_7     = 7'b0000111;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1100111;
  localparam logic [6:0] GLYPH_A     = 7'b1110111;
  localparam logic [6:0] GLYPH_B     = 7'b1111100;
  localparam logic [6:0] GLYPH_C     = 7'b0111001;
  localparam logic [6:0] GLYPH_D     = 7'b1011110;
  localparam logic [6:0] GLYPH_E     = 7'b1111001;
  localparam logic [6:0] GLYPH_F     = 7'b1110001;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
  localparam logic [6:0] GLYPH_DASH  = 7'b1000000;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

  function automatic logic [6:0] nibble_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: return GLYPH_0;
      4'h1: return GLYPH_1;
      4'h2: return GLYPH_2;
      4'h3: return GLYPH_3;
      4'h4: return GLYPH_4;
      4'h5: return GLYPH_5;
      4'h6: return GLYPH_6;
      4'h7: return GLYPH_7;
      4'h8: return GLYPH_8;
      4'h9: return GLYPH_9;
      4'hA: return GLYPH_A;
      4'hB: return GLYPH_B;
      4'hC: return GLYPH_C;
      4'hD: return GLYPH_D;
      4'hE: return GLYPH_E;
      default: return GLYPH_F;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - captures a value and, in decimal mode, runs one double-dabble step per cycle
module bin2bcd_seq #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [BIN_W-1:0]        value_i,
  input  logic                    dec_mode_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] result_o,
  output logic                    ovf_o,
  output logic                    dec_o
);
  localparam int BCD_W = 4*NUM_DIGITS + 4;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic             busy_q, sticky_q, dec_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BIN_W-1:0] val_q, sh_q;
  logic [BCD_W-1:0] bcd_q, adj;
  logic [63:0]      val_ext;
  logic             last;

  always_comb begin
    adj = bcd_q;
    for (int j = 0; j <= NUM_DIGITS; j++) begin
      if (bcd_q[4*j +: 4] >= 4'd5) adj[4*j +: 4] = bcd_q[4*j +: 4] + 4'd3;
    end
  end

  assign last     = busy_q && (cnt_q == CNT_W'(BIN_W - 1));
  assign ready_o  = ~busy_q;
  assign done_o   = last || (start_i && !busy_q && !dec_mode_i);
  assign val_ext  = 64'(val_q);
  assign dec_o    = dec_q;
  assign result_o = dec_q ? bcd_q[4*NUM_DIGITS-1:0] : val_ext[4*NUM_DIGITS-1:0];
  // Bits pushed out of the spare nibble are remembered so wide inputs still flag overflow
  assign ovf_o    = dec_q ? (sticky_q || (bcd_q[BCD_W-1 -: 4] != 4'd0))
                          : ((val_ext >> (4*NUM_DIGITS)) != 64'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      sticky_q <= 1'b0;
      dec_q    <= 1'b0;
      cnt_q    <= '0;
      val_q    <= '0;
      sh_q     <= '0;
      bcd_q    <= '0;
    end else if (start_i && !busy_q) begin
      val_q    <= value_i;
      sh_q     <= value_i;
      bcd_q    <= '0;
      sticky_q <= 1'b0;
      dec_q    <= dec_mode_i;
      cnt_q    <= '0;
      busy_q   <= dec_mode_i;
    end else if (busy_q) begin
      bcd_q    <= {adj[BCD_W-2:0], sh_q[BIN_W-1]};
      sh_q     <= sh_q << 1;
      sticky_q <= sticky_q | adj[BCD_W-1];
      cnt_q    <= cnt_q + CNT_W'(1);
      if (last) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/seg7_multi_display.sv
// rtl/seg7_multi_display.sv - multi-digit 7-segment driver with hex/decimal modes, blanking and blink
module seg7_multi_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [BIN_W-1:0]        value,
  input  logic                    dec_mode,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic                    ready,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] seg
);
  localparam int SEG_W = 7*NUM_DIGITS;
  localparam int BC_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t                  state_q;
  logic                    ready_q, done_q, ovf_q, commit_q, ovf_pend_q, blink_phase_q;
  logic [SEG_W-1:0]        disp_q, codes_q, codes_d, seg_raw;
  logic [BC_W-1:0]         blink_cnt_q;
  logic                    accept, conv_ready, conv_done, conv_ovf, conv_dec, lead;
  logic [4*NUM_DIGITS-1:0] conv_result;

  assign accept = load && ready_q && conv_ready;

  bin2bcd_seq #(.NUM_DIGITS(NUM_DIGITS), .BIN_W(BIN_W)) u_conv (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (accept),
    .value_i    (value),
    .dec_mode_i (dec_mode),
    .ready_o    (conv_ready),
    .done_o     (conv_done),
    .result_o   (conv_result),
    .ovf_o      (conv_ovf),
    .dec_o      (conv_dec)
  );

  // Walk from the top digit down; lead stays set while every digit so far is zero
  always_comb begin
    codes_d = '0;
    lead    = 1'b1;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      if (conv_result[4*i +: 4] != 4'd0) lead = 1'b0;
      if (conv_ovf && conv_dec)
        codes_d[7*i +: 7] = GLYPH_DASH;
      else if (blank_lz && !conv_ovf && lead && (i != 0))
        codes_d[7*i +: 7] = GLYPH_BLANK;
      else
        codes_d[7*i +: 7] = nibble_glyph(conv_result[4*i +: 4]);
    end
  end

  // Codes are staged for one cycle so seg, done and ready all change on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      commit_q   <= 1'b0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      codes_q    <= '0;
    end else begin
      done_q   <= commit_q;
      commit_q <= 1'b0;
      if (commit_q) begin
        disp_q  <= codes_q;
        ovf_q   <= ovf_pend_q;
        ready_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: if (accept) begin
          ready_q <= 1'b0;
          state_q <= dec_mode ? ST_SHIFT : ST_COMMIT;
        end
        ST_SHIFT: if (conv_done) state_q <= ST_COMMIT;
        ST_COMMIT: begin
          codes_q    <= codes_d;
          ovf_pend_q <= conv_ovf;
          commit_q   <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BC_W'(BLINK_DIV - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BC_W'(1);
    end
  end

  always_comb begin
    seg_raw = (blink_en && blink_phase_q) ? '0 : disp_q;
    seg     = ACTIVE_LOW ? ~seg_raw : seg_raw;
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_seg7_multi_display.sv
// tb/tb_seg7_multi_display.sv - table-driven bench for seg7_multi_display (4 digits, 14-bit, active-low)
module tb_seg7_multi_display;
  localparam logic [6:0] S_BL = 7'b1111111;
  localparam logic [6:0] S_DA = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0011000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [27:0] ALL_OFF = 28'hFFFFFFF;

  logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0;
  logic        dec_mode = 1'b0, blank_lz = 1'b0, blink_en = 1'b0;
  logic [13:0] value = '0;
  logic        ready, done, overflow;
  logic [27:0] seg;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  seg7_multi_display #(.NUM_DIGITS(4), .BIN_W(14), .ACTIVE_LOW(1'b1), .BLINK_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .dec_mode (dec_mode),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .ready    (ready),
    .done     (done),
    .overflow (overflow),
    .seg      (seg)
  );

  typedef struct {
    logic [13:0] value;
    logic        dec;
    logic        blz;
    logic [27:0] exp_seg;
    logic        exp_ovf;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [27:0] prev;
    int          n;
    bit          held;
    value = v.value; dec_mode = v.dec; blank_lz = v.blz; load = 1'b1;
    prev = seg;
    tick();
    load = 1'b0;
    check({tag, " ready_drop"}, 32'(ready), 32'd0);
    n = 0; held = 1'b1;
    while (n < 60) begin
      tick();
      n++;
      if (done) break;
      if (seg !== prev) held = 1'b0;
    end
    check({tag, " latency"}, n, v.dec ? 32'd16 : 32'd2);
    check({tag, " hold_old"}, 32'(held), 32'd1);
    check({tag, " seg"}, 32'(seg), 32'(v.exp_seg));
    check({tag, " overflow"}, 32'(overflow), 32'(v.exp_ovf));
    check({tag, " ready_back"}, 32'(ready), 32'd1);
    tick();
    check({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [27:0] s[24];
    logic [27:0] content;
    int          n, f;
    bit          ok, found;

    vecs[0] = '{14'h1A3F, 1'b0, 1'b0, {S1, SA, S3, SF}, 1'b0};
    vecs[1] = '{14'd1234, 1'b1, 1'b0, {S1, S2, S3, S4}, 1'b0};
    vecs[2] = '{14'd10000, 1'b1, 1'b0, {S_DA, S_DA, S_DA, S_DA}, 1'b1};
    vecs[3] = '{14'd7, 1'b1, 1'b1, {S_BL, S_BL, S_BL, S7}, 1'b0};
    vecs[4] = '{14'd0, 1'b1, 1'b1, {S_BL, S_BL, S_BL, S0}, 1'b0};
    vecs[5] = '{14'd9999, 1'b1, 1'b0, {S9, S9, S9, S9}, 1'b0};
    vecs[6] = '{14'h00B0, 1'b0, 1'b1, {S_BL, S_BL, SB, S0}, 1'b0};
    vecs[7] = '{14'd16383, 1'b1, 1'b1, {S_DA, S_DA, S_DA, S_DA}, 1'b1};
    vecs[8] = '{14'd1005, 1'b1, 1'b1, {S1, S0, S0, S5}, 1'b0};

    // Reset state
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("reset seg", 32'(seg), 32'(ALL_OFF));
    check("reset ready", 32'(ready), 32'd1);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset done", 32'(done), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Second load during a decimal conversion is ignored
    value = 14'd1234; dec_mode = 1'b1; blank_lz = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    repeat (4) begin tick(); n++; end
    value = 14'd42; load = 1'b1;
    tick(); n++;
    load = 1'b0;
    while (n < 60) begin
      tick(); n++;
      if (done) break;
    end
    check("busy_load latency", n, 32'd16);
    check("busy_load seg", 32'(seg), 32'({S1, S2, S3, S4}));

    // Load accepted in the done cycle
    value = 14'h00B0; dec_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    check("done_cycle_load ready", 32'(ready), 32'd0);
    tick();
    check("done_cycle_load early", 32'(done), 32'd0);
    tick();
    check("done_cycle_load done", 32'(done), 32'd1);
    check("done_cycle_load seg", 32'(seg), 32'({S0, S0, SB, S0}));

    // Blink alternates contents and all-off every BLINK_DIV cycles
    content = {S0, S0, SB, S0};
    blink_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      s[i] = seg;
    end
    found = 1'b0; f = 1;
    for (int i = 1; i <= 8; i++) begin
      if (!found && s[i] !== s[i-1]) begin found = 1'b1; f = i; end
    end
    check("blink toggles", 32'(found), 32'd1);
    ok = ((s[f] === content) && (s[f-1] === ALL_OFF)) || ((s[f] === ALL_OFF) && (s[f-1] === content));
    check("blink values", 32'(ok), 32'd1);
    ok = 1'b1;
    for (int j = f; j < f + 16; j++) begin
      if (s[j] !== ((((j - f) / 4) % 2 == 0) ? s[f] : s[f-1])) ok = 1'b0;
    end
    check("blink period", 32'(ok), 32'd1);
    blink_en = 1'b0;
    #1;
    check("blink off seg", 32'(seg), 32'(content));

    // Reset in the middle of a decimal conversion
    run_vec(vecs[2], "pre_reset");
    value = 14'd1234; dec_mode = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    check("midreset seg", 32'(seg), 32'(ALL_OFF));
    check("midreset ready", 32'(ready), 32'd1);
    check("midreset overflow", 32'(overflow), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_vec(vecs[0], "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
